mem_port_arbiter: RTL and testbench

Shares the single-ported word memory between the core's instruction-fetch requester and its load/store requester. Arbitrates per cycle, drives the memory port, and routes the one-cycle-latency read data back to whichever requester owns it. Sits between the fetch/LSU stages and the `memory` instance. It replaces the dual iaddr/daddr usage when the memory is built single-ported.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one single-ported word memory between fetch and load/store.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_I     = 2'd1,
    RESP_D_RD  = 2'd2,
    RESP_D_WR  = 2'd3
  } resp_t;

  resp_t resp;
  resp_t resp_nxt;
  logic  force_i;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("mem_port_arbiter: STARVE_LIMIT must be within 1..15");
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned STARVE_W = 4;

  logic [STARVE_W-1:0] starve;

  assign force_i = i_req && (starve == STARVE_W'(STARVE_LIMIT));

  // Counts cycles where fetch waits behind data; any fetch grant or idle fetch clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (i_gnt || !i_req) begin
      starve <= '0;
    end else if (d_req && (starve != STARVE_W'(STARVE_LIMIT))) begin
      starve <= starve + STARVE_W'(1);
    end
  end
`else
  assign force_i = 1'b0;
`endif

  // Data wins unless the guard forces fetch; nothing is granted while in reset.
  assign d_gnt = !rst && d_req && !force_i;
  assign i_gnt = !rst && i_req && (!d_req || force_i);

  assign m_en    = i_gnt || d_gnt;
  assign m_we    = d_gnt && d_we;
  assign m_addr  = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
  assign m_wdata = d_gnt ? d_wdata : 32'd0;

  always_comb begin
    resp_nxt = RESP_NONE;
    if (d_gnt) begin
      resp_nxt = d_we ? RESP_D_WR : RESP_D_RD;
    end else if (i_gnt) begin
      resp_nxt = RESP_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp <= RESP_NONE;
    end else begin
      resp <= resp_nxt;
    end
  end

  // Route the one-cycle-late memory data to its owner; responses are dropped during reset.
  always_comb begin
    i_valid = 1'b0;
    i_rdata = 32'd0;
    d_valid = 1'b0;
    d_rdata = 32'd0;
    if (!rst) begin
      case (resp)
        RESP_I: begin
          i_valid = !i_flush;
          i_rdata = m_rdata;
        end
        RESP_D_RD: begin
          d_valid = 1'b1;
          d_rdata = m_rdata;
        end
        RESP_D_WR: begin
          d_valid = 1'b1;
        end
        default: begin
          i_valid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency word memory model.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 16;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic              i_gnt;
  logic              i_valid;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [31:0]       d_rdata;
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  int n_assert;
  int n_fail;

  logic [31:0] mem [256];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_flush (i_flush),
    .i_gnt   (i_gnt),
    .i_valid (i_valid),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_gnt   (d_gnt),
    .d_valid (d_valid),
    .d_rdata (d_rdata),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preloaded during reset, read data stays stale when not accessed.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hCAFE_0000 | 32'(i);
      mem[8'h04] <= 32'h0000_0013;
      mem[8'h08] <= 32'hA5A5_0008;
      mem[8'h10] <= 32'hDEAD_BEEF;
    end else if (m_en && m_we) begin
      mem[m_addr[7:0]] <= m_wdata;
    end
    if (m_en && !m_we) m_rdata <= mem[m_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    i_req    = 1'b1;
    i_addr   = 16'h0004;
    i_flush  = 1'b0;
    d_req    = 1'b1;
    d_we     = 1'b1;
    d_addr   = 16'h0010;
    d_wdata  = 32'h1111_2222;

    // Reset holds off all grants even with both requests high
    @(negedge clk); #1;
    chk("rst_i_gnt", 32'(i_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_m_en", 32'(m_en), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_i_valid", 32'(i_valid), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("idle_m_en", 32'(m_en), 32'd0);
    chk("idle_i_valid", 32'(i_valid), 32'd0);
    chk("idle_i_rdata", i_rdata, 32'd0);
    chk("idle_d_rdata", d_rdata, 32'd0);

    // Single fetch
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0004;
    #1;
    chk("rd_i_gnt", 32'(i_gnt), 32'd1);
    chk("rd_d_gnt", 32'(d_gnt), 32'd0);
    chk("rd_m_en", 32'(m_en), 32'd1);
    chk("rd_m_we", 32'(m_we), 32'd0);
    chk("rd_m_addr", 32'(m_addr), 32'h0004);
    @(negedge clk);
    i_req = 1'b0;
    #1;
    chk("rd_i_valid", 32'(i_valid), 32'd1);
    chk("rd_i_rdata", i_rdata, 32'h0000_0013);
    chk("rd_d_valid", 32'(d_valid), 32'd0);
    chk("rd_m_en_idle", 32'(m_en), 32'd0);
    @(negedge clk); #1;
    chk("rd_i_valid_end", 32'(i_valid), 32'd0);
    chk("rd_i_rdata_end", i_rdata, 32'd0);

    // Contention: data first, fetch the next cycle
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0008;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    #1;
    chk("ct_d_gnt", 32'(d_gnt), 32'd1);
    chk("ct_i_gnt", 32'(i_gnt), 32'd0);
    chk("ct_m_addr", 32'(m_addr), 32'h0010);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("ct_d_valid", 32'(d_valid), 32'd1);
    chk("ct_d_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("ct_i_gnt2", 32'(i_gnt), 32'd1);
    chk("ct_m_addr2", 32'(m_addr), 32'h0008);
    chk("ct_i_valid_early", 32'(i_valid), 32'd0);
    @(negedge clk);
    i_req = 1'b0;
    #1;
    chk("ct_i_valid", 32'(i_valid), 32'd1);
    chk("ct_i_rdata", i_rdata, 32'hA5A5_0008);
    chk("ct_d_valid_end", 32'(d_valid), 32'd0);
    chk("ct_d_rdata_end", d_rdata, 32'd0);

    // Write then back-to-back read of the same word
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 32'h1234_5678;
    #1;
    chk("wr_d_gnt", 32'(d_gnt), 32'd1);
    chk("wr_m_en", 32'(m_en), 32'd1);
    chk("wr_m_we", 32'(m_we), 32'd1);
    chk("wr_m_addr", 32'(m_addr), 32'h0020);
    chk("wr_m_wdata", m_wdata, 32'h1234_5678);
    @(negedge clk);
    d_we = 1'b0;
    #1;
    chk("wr_d_valid", 32'(d_valid), 32'd1);
    chk("wr_d_rdata", d_rdata, 32'd0);
    chk("wr_m_we_rd", 32'(m_we), 32'd0);
    chk("wr_rd_gnt", 32'(d_gnt), 32'd1);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("wr_rb_valid", 32'(d_valid), 32'd1);
    chk("wr_rb_rdata", d_rdata, 32'h1234_5678);

    // Flush drops the pending fetch response but not the fetch granted alongside it
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0004;
    #1;
    chk("fl_i_gnt", 32'(i_gnt), 32'd1);
    @(negedge clk);
    i_flush = 1'b1; i_addr = 16'h0008;
    #1;
    chk("fl_i_valid", 32'(i_valid), 32'd0);
    chk("fl_i_gnt2", 32'(i_gnt), 32'd1);
    @(negedge clk);
    i_flush = 1'b0; i_req = 1'b0;
    #1;
    chk("fl_i_valid2", 32'(i_valid), 32'd1);
    chk("fl_i_rdata2", i_rdata, 32'hA5A5_0008);

    // Continuous contention
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    for (int k = 0; k < 20; k++) begin
      logic exp_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_i = ((k % 5) == 4);
`else
      exp_i = 1'b0;
`endif
      #1;
      chk($sformatf("sv_i_gnt_%0d", k), 32'(i_gnt), 32'(exp_i));
      chk($sformatf("sv_d_gnt_%0d", k), 32'(d_gnt), 32'(!exp_i));
      @(negedge clk);
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Reset in the cycle a fetch response is due
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0004;
    #1;
    chk("mr_i_gnt", 32'(i_gnt), 32'd1);
    @(negedge clk);
    rst = 1'b1; d_req = 1'b1;
    #1;
    chk("mr_i_valid", 32'(i_valid), 32'd0);
    chk("mr_i_rdata", i_rdata, 32'd0);
    chk("mr_m_en", 32'(m_en), 32'd0);
    chk("mr_i_gnt_rst", 32'(i_gnt), 32'd0);
    chk("mr_d_gnt_rst", 32'(d_gnt), 32'd0);
    @(negedge clk); #1;
    chk("mr_m_en2", 32'(m_en), 32'd0);
    chk("mr_d_valid2", 32'(d_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0;
    #1;
    chk("mr_i_gnt_after", 32'(i_gnt), 32'd1);
    chk("mr_i_valid_after", 32'(i_valid), 32'd0);
    chk("mr_m_addr_after", 32'(m_addr), 32'h0004);
    @(negedge clk);
    i_req = 1'b0;
    #1;
    chk("mr_i_valid_resp", 32'(i_valid), 32'd1);
    chk("mr_i_rdata_resp", i_rdata, 32'h0000_0013);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
